// File: rtl/lut_multiplier_32b_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier controller around a registered 2-bit LUT stage.
// Issues one 2-bit digit of B per cycle and shift-accumulates the stage's partial products.
module lut_multiplier_32b_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_32b,
  input  logic               resetn_32b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [1:0]         mul_digit,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int unsigned NDIG = WIDTH / 2;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NDIG - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      sh_digit;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] drain_sum;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    sh_digit  = idx_q - 1'b1;
    drain_sum = acc_q + (mul_result << {LastIdx, 1'b0});

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // The stage output lags the issued digit by one cycle, so idx 0 has nothing to add yet.
        if (idx_q != '0) begin
          acc_d = acc_q + (mul_result << {sh_digit, 1'b0});
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d   = drain_sum;
        prod_d  = drain_sum;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_product = prod_q;
  assign mul_a       = a_q;
  assign mul_digit   = (state_q == StRun) ? b_q[{idx_q, 1'b0} +: 2] : 2'b00;

endmodule

// File: tb/tb_lut_multiplier_32b_seq.sv
// Bench for lut_multiplier_32b_seq: models the registered 2-bit stage and checks products
// against plain 64-bit multiplication, digit issue order, latency and handshake behaviour.
module tb_lut_multiplier_32b_seq;

  logic        clk_32b = 1'b0;
  logic        resetn_32b = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] mul_a;
  logic [1:0]  mul_digit;
  logic [63:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_product;

  int checks = 0;
  int errors = 0;

  lut_multiplier_32b_seq #(.WIDTH(32)) dut (
    .clk_32b    (clk_32b),
    .resetn_32b (resetn_32b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_digit  (mul_digit),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product)
  );

  always #5 clk_32b = ~clk_32b;

  // Registered 2-bit LUT stage: product of the operands presented in the previous cycle.
  always @(posedge clk_32b) mul_result <= {32'b0, mul_a} * {62'b0, mul_digit};

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_32b);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [1:0] digit_of(input logic [31:0] b, input int i);
    logic [31:0] s;
    s = b >> (2 * i);
    return s[1:0];
  endfunction

  // One full operation from IDLE; hold = cycles out_ready stays low in DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    exp = ref_mul(a, b);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    for (int i = 0; i < 16; i++) begin
      chk("run_in_ready", 64'(in_ready), 64'd0);
      chk("run_digit", 64'(mul_digit), 64'(digit_of(b, i)));
      chk("run_mul_a", 64'(mul_a), 64'(a));
      chk("run_out_valid", 64'(out_valid), 64'd0);
      step();
    end
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_digit", 64'(mul_digit), 64'd0);
    step();
    chk("done_out_valid", 64'(out_valid), 64'd1);
    chk("done_product", out_product, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom;
      in_b = $urandom;
      step();
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_product", out_product, exp);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_mul_a", 64'(mul_a), 64'(a));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("after_out_valid", 64'(out_valid), 64'd0);
    chk("after_in_ready", 64'(in_ready), 64'd1);
    chk("after_product", out_product, exp);
    chk("after_digit", 64'(mul_digit), 64'd0);
  endtask

  initial begin
    logic [31:0] a1, b1, a2, b2;
    logic        seen_valid;

    // Reset values while reset is held
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_digit", 64'(mul_digit), 64'd0);
    step();
    step();
    resetn_32b = 1'b1;
    step();

    do_op(32'd3, 32'd5, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(32'd0, 32'h1234_5678, 0);
    do_op(32'h10, 32'hE4, 0);
    do_op($urandom, $urandom, 10);

    // Reset mid-RUN at idx=7, asserted between clock edges
    in_a = 32'hDEAD_BEEF;
    in_b = 32'hCAFE_F00D;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_digit_idx7", 64'(mul_digit), 64'(digit_of(32'hCAFE_F00D, 7)));
    #2;
    resetn_32b = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_product", out_product, 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_digit", 64'(mul_digit), 64'd0);
    step();
    resetn_32b = 1'b1;
    seen_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    out_ready = 1'b0;
    chk("aborted_no_valid", 64'(seen_valid), 64'd0);
    do_op(32'd7, 32'd9, 0);

    // Back-to-back with in_valid and out_ready held high
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    in_a = a1;
    in_b = b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_a = a2;
    in_b = b2;
    chk("b2b_first_accept", 64'(in_ready), 64'd0);
    for (int i = 0; i < 17; i++) step();
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_prod1", out_product, ref_mul(a1, b1));
    step();
    chk("b2b_idle_valid", 64'(out_valid), 64'd0);
    chk("b2b_idle_ready", 64'(in_ready), 64'd1);
    step();
    chk("b2b_second_accept", 64'(in_ready), 64'd0);
    chk("b2b_second_digit0", 64'(mul_digit), 64'(digit_of(b2, 0)));
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("b2b_valid2", 64'(out_valid), 64'd1);
    chk("b2b_prod2", out_product, ref_mul(a2, b2));
    step();
    out_ready = 1'b0;
    chk("b2b_end_ready", 64'(in_ready), 64'd1);

    // Randomized operations with random DONE hold times
    for (int n = 0; n < 8; n++) begin
      do_op($urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_multiplier_32b_seq.md
Name: lut_multiplier_32b_seq

Overview:
Sequential 32x32 unsigned multiplier controller that sits directly around the registered 2-bit LUT multiplier stage. It feeds that stage one 2-bit digit of operand B per cycle, with operand A held constant. It consumes the stage's registered partial products and shift-accumulates them into a 64-bit product. A valid/ready handshake is used on both the input and output sides.

Parameters:
WIDTH, 32, operand width; must be even. Number of digits NDIG = WIDTH/2 = 16. Product width is 2*WIDTH.

Ports:
clk_32b  input  1  clock, rising edge; shared with the 2-bit stage
resetn_32b  input  1  asynchronous active-low reset
in_valid  input  1  operands A/B offered
in_ready  output  1  block can accept operands
in_a  input  WIDTH  multiplicand A
in_b  input  WIDTH  multiplier B
mul_a  output  WIDTH  to the 2-bit stage's 32-bit operand
mul_digit  output  2  to the 2-bit stage's 2-bit operand
mul_result  input  2*WIDTH  registered partial product from the 2-bit stage, one cycle after mul_a/mul_digit
out_valid  output  1  product available
out_ready  input  1  downstream accepts product
out_product  output  2*WIDTH  A*B

Behaviour:
- Reset (async, resetn_32b=0) forces the following, independent of clk:
  - state=IDLE, in_ready=1, out_valid=0, out_product=0, mul_a=0, mul_digit=0.
  - Internal accumulator, digit index and operand latches are cleared to 0.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch A and B, clear acc, set idx=0, go to RUN.
- RUN (NDIG cycles, idx=0..NDIG-1):
  - mul_a = latched A; mul_digit = B[2*idx+1:2*idx], so digits are issued LSB first.
  - For idx>=1, the edge performs acc <= acc + (mul_result << 2*(idx-1)).
  - After idx=NDIG-1, go to DRAIN.
- DRAIN (1 cycle):
  - The edge performs acc <= acc + (mul_result << 2*(NDIG-1)).
  - Go to DONE.
- DONE:
  - out_valid=1 and out_product=acc; both held stable until out_ready=1.
  - On an edge with out_ready=1, go to IDLE.
  - out_product keeps its last value in IDLE.
- in_ready=1 only in IDLE. in_valid is ignored in all other states, so there is never more than one operation in flight.
- Latency: accept at edge E0 -> out_valid rises after edge E0+NDIG+1 (E17). Minimum issue interval is 19 cycles with out_ready held high.
- Arithmetic:
  - Unsigned; acc is 2*WIDTH bits and additions are modulo 2^(2*WIDTH).
  - The full product always fits, so no bits are lost.
  - mul_result bits above WIDTH+1 are treated as zero-by-construction but are still added as-is.
- mul_digit and mul_a outside RUN:
  - mul_digit is driven to 0 and mul_a holds A.
  - The values of mul_result seen in those cycles are never accumulated.
- Simultaneous events:
  - out_ready and in_valid both high in DONE: the product is consumed, and the new operands are accepted at the first IDLE edge, not in DONE.
  - out_ready high outside DONE has no effect.
- Reset mid-operation (any state): abort immediately to the reset values above; no out_valid is produced for the aborted operation.
- Operands changing on in_a/in_b after acceptance have no effect.

Test Plan:
1. A=3, B=5 accepted at E0 -> out_valid rises after E17, out_product=0x000000000000000F; in_ready=0 from E0 through DONE.
2. A=0xFFFFFFFF, B=0xFFFFFFFF -> out_product=0xFFFFFFFE00000001. Also A=0, B=0x12345678 -> 0.
3. B=0x000000E4, A=0x10 -> mul_digit sequence over RUN cycles is 0,1,2,3, then 0 for the remaining 12 cycles; mul_a=0x10 throughout; out_product=0xE40.
4. out_ready held low for 10 cycles in DONE -> out_valid and out_product stable; in_valid pulses during this window are not accepted; accepted one cycle after out_ready is raised.
5. resetn_32b pulsed low mid-RUN (idx=7), asynchronous to clk -> outputs immediately reset values, no out_valid; a following A=7, B=9 completes with 63.
6. Back-to-back: two operations with in_valid and out_ready always high -> second accept exactly 19 cycles after the first; both products correct.
